// File: rtl/mips32.sv
// mips32: five-stage in-order MIPS-like core with one unified word-addressed
// memory, full EX-operand forwarding, and no interlocks. Branches resolve in
// EX with a two-slot squash. HLT freezes fetch and halts the core once it
// retires.
module mips32 #(
  parameter int MEM_DEPTH = 1024
) (
  input  logic clk,
  input  logic rst,
  output logic halted
);
  localparam int AW = $clog2(MEM_DEPTH);

  localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_AND = 6'b000010,
                         OP_OR = 6'b000011, OP_SLT = 6'b000100, OP_MUL = 6'b000101,
                         OP_LW = 6'b001000, OP_SW = 6'b001001, OP_ADDI = 6'b001010,
                         OP_SUBI = 6'b001011, OP_SLTI = 6'b001100, OP_BNEQZ = 6'b001101,
                         OP_BEQZ = 6'b001110, OP_HLT = 6'b111111;

  logic [31:0] Reg [0:31];
  logic [31:0] mem [0:MEM_DEPTH-1];
  logic [31:0] PC;
  logic        HALTED;
  logic        stop;

  // IF/ID
  logic        vld_p0;
  logic [31:0] ir_p0, npc_p0;
  // ID/EX
  logic               vld_p1, wr_p1;
  logic [5:0]         op_p1;
  logic [4:0]         rs_p1, rt_p1, dst_p1;
  logic signed [31:0] a_p1, b_p1, imm_p1;
  logic [31:0]        npc_p1;
  // EX/MEM
  logic               vld_p2, wr_p2, ld_p2, st_p2, hlt_p2;
  logic [4:0]         dst_p2;
  logic signed [31:0] alu_p2, sd_p2;
  // MEM/WB
  logic               vld_p3, wr_p3, hlt_p3;
  logic [4:0]         dst_p3;
  logic signed [31:0] val_p3;

  assign halted = HALTED;

  logic [5:0]         op_id;
  logic [4:0]         rs_id, rt_id, rd_id, dst_id;
  logic signed [31:0] imm_id, rsv_id, rtv_id;
  logic               wr_id, hlt_id;

  assign op_id  = ir_p0[31:26];
  assign rs_id  = ir_p0[25:21];
  assign rt_id  = ir_p0[20:16];
  assign rd_id  = ir_p0[15:11];
  assign imm_id = {{16{ir_p0[15]}}, ir_p0[15:0]};
  assign hlt_id = vld_p0 && (op_id == OP_HLT);

  // Decode destination and register-file read with same-cycle WB bypass.
  always_comb begin
    wr_id  = 1'b0;
    dst_id = rt_id;
    case (op_id)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
        wr_id  = 1'b1;
        dst_id = rd_id;
      end
      OP_ADDI, OP_SUBI, OP_SLTI, OP_LW: wr_id = 1'b1;
      default: ;
    endcase
    rsv_id = Reg[rs_id];
    rtv_id = Reg[rt_id];
    if (vld_p3 && wr_p3 && dst_p3 == rs_id) rsv_id = val_p3;
    if (vld_p3 && wr_p3 && dst_p3 == rt_id) rtv_id = val_p3;
    if (rs_id == 5'd0) rsv_id = '0;
    if (rt_id == 5'd0) rtv_id = '0;
  end

  logic signed [31:0] fa, fb, alu_ex;
  logic               taken_ex;
  logic [31:0]        target_ex;

  // EX operand forwarding (EX/MEM ALU result beats MEM/WB) and ALU/branch.
  always_comb begin
    fa = a_p1;
    fb = b_p1;
    if (rs_p1 != 5'd0 && vld_p3 && wr_p3 && dst_p3 == rs_p1) fa = val_p3;
    if (rt_p1 != 5'd0 && vld_p3 && wr_p3 && dst_p3 == rt_p1) fb = val_p3;
    if (rs_p1 != 5'd0 && vld_p2 && wr_p2 && !ld_p2 && dst_p2 == rs_p1) fa = alu_p2;
    if (rt_p1 != 5'd0 && vld_p2 && wr_p2 && !ld_p2 && dst_p2 == rt_p1) fb = alu_p2;
    alu_ex = '0;
    case (op_p1)
      OP_ADD:       alu_ex = fa + fb;
      OP_SUB:       alu_ex = fa - fb;
      OP_AND:       alu_ex = fa & fb;
      OP_OR:        alu_ex = fa | fb;
      OP_SLT:       alu_ex = {31'd0, fa < fb};
      OP_MUL:       alu_ex = fa * fb;
      OP_ADDI:      alu_ex = fa + imm_p1;
      OP_SUBI:      alu_ex = fa - imm_p1;
      OP_SLTI:      alu_ex = {31'd0, fa < imm_p1};
      OP_LW, OP_SW: alu_ex = fa + imm_p1;
      default:      alu_ex = '0;
    endcase
    taken_ex  = vld_p1 && ((op_p1 == OP_BNEQZ && fa != 0) || (op_p1 == OP_BEQZ && fa == 0));
    target_ex = npc_p1 + imm_p1;
  end

  // Control state: PC, valid bits, fetch stop and halt flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC     <= '0;
      HALTED <= 1'b0;
      stop   <= 1'b0;
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else if (!HALTED) begin
      HALTED <= vld_p3 && hlt_p3;
      stop   <= stop || (hlt_id && !taken_ex);
      vld_p0 <= !(taken_ex || stop || hlt_id);
      vld_p1 <= vld_p0 && !taken_ex;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
      if (taken_ex) PC <= target_ex;
      else if (!stop && !hlt_id) PC <= PC + 32'd1;
    end
  end

  // Pipeline data registers; validity is carried by the vld_pN bits.
  always_ff @(posedge clk) begin
    ir_p0  <= mem[PC[AW-1:0]];
    npc_p0 <= PC + 32'd1;
    op_p1  <= op_id;
    rs_p1  <= rs_id;
    rt_p1  <= rt_id;
    dst_p1 <= dst_id;
    wr_p1  <= wr_id;
    a_p1   <= rsv_id;
    b_p1   <= rtv_id;
    imm_p1 <= imm_id;
    npc_p1 <= npc_p0;
    alu_p2 <= alu_ex;
    sd_p2  <= fb;
    dst_p2 <= dst_p1;
    wr_p2  <= wr_p1;
    ld_p2  <= (op_p1 == OP_LW);
    st_p2  <= (op_p1 == OP_SW);
    hlt_p2 <= (op_p1 == OP_HLT);
    val_p3 <= ld_p2 ? mem[alu_p2[AW-1:0]] : alu_p2;
    dst_p3 <= dst_p2;
    wr_p3  <= wr_p2;
    hlt_p3 <= hlt_p2;
  end

  // MEM-stage store.
  always_ff @(posedge clk) begin
    if (!HALTED && vld_p2 && st_p2) mem[alu_p2[AW-1:0]] <= sd_p2;
  end

  // WB-stage register write; R0 is never written.
  always_ff @(posedge clk) begin
    if (!HALTED && vld_p3 && wr_p3 && dst_p3 != 5'd0) Reg[dst_p3] <= val_p3;
  end
endmodule

// File: tb/tb_mips32.sv
// tb_mips32: directed programs for the mips32 pipeline with hand-computed
// register/memory results, halt freeze and asynchronous reset checks.
module tb_mips32;
  logic clk;
  logic rst;
  logic halted;
  int   n_cmp;
  int   n_bad;
  logic [31:0] pc_snap;

  localparam logic [31:0] NOP = 32'h3C00_0000;
  localparam logic [31:0] HLT = 32'hFC00_0000;

  mips32 #(.MEM_DEPTH(1024)) dut (.clk(clk), .rst(rst), .halted(halted));

  always #10 clk = ~clk;

  function automatic logic [31:0] rr(input logic [5:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] rt,
                                     input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) dut.mem[i] = NOP;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_halt(input string tag, input int budget);
    int n;
    n = 0;
    while (halted !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, halted}, 32'd1);
  endtask

  task automatic async_rst_check(input string tag);
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk({tag, "_pc"}, dut.PC, 32'd0);
    chk({tag, "_halted"}, {31'd0, halted}, 32'd0);
  endtask

  task automatic load_fact();
    clear_mem();
    dut.mem[200] = 32'd7;
    dut.mem[198] = 32'd0;
    dut.mem[0]  = ri(6'b001010, 5'd10, 5'd0, 16'd200);
    dut.mem[1]  = ri(6'b001010, 5'd2, 5'd0, 16'd1);
    dut.mem[2]  = NOP;
    dut.mem[3]  = ri(6'b001000, 5'd3, 5'd10, 16'd0);
    dut.mem[4]  = NOP;
    dut.mem[5]  = rr(6'b000101, 5'd2, 5'd2, 5'd3);
    dut.mem[6]  = ri(6'b001011, 5'd3, 5'd3, 16'd1);
    dut.mem[7]  = NOP;
    dut.mem[8]  = ri(6'b001101, 5'd0, 5'd3, 16'hFFFC);
    dut.mem[9]  = ri(6'b001001, 5'd2, 5'd10, 16'hFFFE);
    dut.mem[10] = HLT;
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    n_cmp = 0;
    n_bad = 0;
    #25;
    chk("reset_pc", dut.PC, 32'd0);
    chk("reset_halted", {31'd0, halted}, 32'd0);

    // ALU chain with back-to-back forwarding
    clear_mem();
    dut.mem[0] = ri(6'b001010, 5'd1, 5'd0, 16'd10);
    dut.mem[1] = ri(6'b001010, 5'd2, 5'd0, 16'd20);
    dut.mem[2] = 32'h0022_2000;
    dut.mem[3] = HLT;
    release_rst();
    wait_halt("chain_halt", 40);
    chk("chain_r1", dut.Reg[1], 32'd10);
    chk("chain_r2", dut.Reg[2], 32'd20);
    chk("chain_r4", dut.Reg[4], 32'd30);
    chk("chain_pc", dut.PC, 32'd4);

    // state frozen after halt
    pc_snap = dut.PC;
    repeat (6) @(negedge clk);
    chk("frozen_pc", dut.PC, 32'd4);
    chk("frozen_r4", dut.Reg[4], 32'd30);
    chk("frozen_halted", {31'd0, halted}, 32'd1);
    async_rst_check("rst_after_halt");

    // factorial, interrupted by reset mid-run
    load_fact();
    release_rst();
    repeat (12) @(negedge clk);
    chk("midrun_not_halted", {31'd0, halted}, 32'd0);
    async_rst_check("rst_midrun");

    // factorial, full run
    load_fact();
    release_rst();
    wait_halt("fact_halt", 150);
    chk("fact_mem198", dut.mem[198], 32'd5040);
    chk("fact_r2", dut.Reg[2], 32'd5040);
    chk("fact_r3", dut.Reg[3], 32'd0);
    chk("fact_pc", dut.PC, 32'd11);
    rst = 1'b1;

    // taken branch squashes the two younger instructions
    clear_mem();
    dut.Reg[5] = 32'h0000_1111;
    dut.Reg[6] = 32'h0000_2222;
    dut.mem[0] = ri(6'b001010, 5'd1, 5'd0, 16'd1);
    dut.mem[1] = ri(6'b001110, 5'd0, 5'd0, 16'd2);
    dut.mem[2] = ri(6'b001010, 5'd5, 5'd0, 16'd9);
    dut.mem[3] = ri(6'b001010, 5'd6, 5'd0, 16'd9);
    dut.mem[4] = HLT;
    release_rst();
    wait_halt("squash_halt", 40);
    chk("squash_r1", dut.Reg[1], 32'd1);
    chk("squash_r5", dut.Reg[5], 32'h0000_1111);
    chk("squash_r6", dut.Reg[6], 32'h0000_2222);
    chk("squash_pc", dut.PC, 32'd5);
    rst = 1'b1;

    // R0 stays zero
    clear_mem();
    dut.Reg[7] = 32'h0000_DEAD;
    dut.mem[0] = ri(6'b001010, 5'd0, 5'd0, 16'd5);
    dut.mem[1] = rr(6'b000000, 5'd7, 5'd0, 5'd0);
    dut.mem[2] = HLT;
    release_rst();
    wait_halt("r0_halt", 40);
    chk("r0_r7", dut.Reg[7], 32'd0);
    rst = 1'b1;

    // signed compares, logic ops, store/load forwarding, unknown opcode
    clear_mem();
    dut.mem[0]  = ri(6'b001010, 5'd1, 5'd0, 16'hFFFB);
    dut.mem[1]  = ri(6'b001010, 5'd2, 5'd0, 16'd3);
    dut.mem[2]  = rr(6'b000100, 5'd3, 5'd1, 5'd2);
    dut.mem[3]  = rr(6'b000001, 5'd4, 5'd2, 5'd1);
    dut.mem[4]  = ri(6'b001001, 5'd4, 5'd0, 16'd100);
    dut.mem[5]  = rr(6'b000010, 5'd5, 5'd1, 5'd2);
    dut.mem[6]  = rr(6'b000011, 5'd6, 5'd1, 5'd2);
    dut.mem[7]  = ri(6'b001100, 5'd7, 5'd2, 16'hFFFF);
    dut.mem[8]  = ri(6'b001000, 5'd8, 5'd0, 16'd100);
    dut.mem[9]  = NOP;
    dut.mem[10] = rr(6'b000000, 5'd9, 5'd8, 5'd8);
    dut.mem[11] = rr(6'b000101, 5'd10, 5'd1, 5'd1);
    dut.mem[12] = HLT;
    release_rst();
    wait_halt("mix_halt", 60);
    chk("mix_r1", dut.Reg[1], 32'hFFFF_FFFB);
    chk("mix_slt", dut.Reg[3], 32'd1);
    chk("mix_sub", dut.Reg[4], 32'd8);
    chk("mix_sw", dut.mem[100], 32'd8);
    chk("mix_and", dut.Reg[5], 32'd3);
    chk("mix_or", dut.Reg[6], 32'hFFFF_FFFB);
    chk("mix_slti", dut.Reg[7], 32'd0);
    chk("mix_lw", dut.Reg[8], 32'd8);
    chk("mix_ldfwd", dut.Reg[9], 32'd16);
    chk("mix_mul", dut.Reg[10], 32'd25);
    chk("mix_pc", dut.PC, 32'd13);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
